// File: rtl/fc_rx_framer.sv
// FC 8G receive framer: delineates SOF/EOF-bounded frames from the aligned 36-bit RX stream
// and forwards them as Avalon-ST packets, flagging runt/oversize/aborted frames.
module fc_rx_framer #(
  parameter int unsigned MAX_FRAME_WORDS = 537,
  parameter int unsigned MIN_FRAME_WORDS = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [35:0] in_data,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic        out_error,
  output logic        in_frame,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [9:0]  MAX_W = 10'(MAX_FRAME_WORDS);
  localparam logic [10:0] MIN_W = 11'(MIN_FRAME_WORDS);

  state_t      state, state_nxt;
  logic [9:0]  cnt;
  logic        h_valid, h_sop, h_eop, h_err;
  logic [31:0] h_data;

  logic [3:0]  kin;
  logic [31:0] din;
  logic        is_os, is_sof, is_eof, is_data;

  logic        emit, abort, load, ld_sop, ld_eop, ld_err;
  logic        emit_eop, emit_err;

  assign kin = in_data[35:32];
  assign din = in_data[31:0];

  always_comb begin
    is_os   = (kin == 4'b1000) && (din[31:24] == 8'hBC);
    is_sof  = is_os && (din[23:16] == 8'hB5) && (din[15:8] == din[7:0]) &&
              ((din[12:8] == 5'h16) || (din[12:8] == 5'h17) || (din[12:8] == 5'h18));
    is_eof  = is_os && ((din[23:16] == 8'h95) || (din[23:16] == 8'hB5)) &&
              (din[15:8] == din[7:0]) &&
              ((din[15:8] == 8'h35) || (din[15:8] == 8'h75) ||
               (din[15:8] == 8'hD5) || (din[15:8] == 8'hF5));
    is_data = (kin == 4'h0);
  end

  // In FRAME the hold register is always occupied, so every input cycle emits it;
  // 'abort' forces eop/err onto the emitted word.
  always_comb begin
    emit      = 1'b0;
    abort     = 1'b0;
    load      = 1'b0;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    ld_err    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        emit = h_valid;
        if (in_valid && is_sof) begin
          load      = 1'b1;
          ld_sop    = 1'b1;
          state_nxt = FRAME;
        end
      end
      FRAME: begin
        emit = 1'b1;
        if (!in_valid) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (is_data) begin
          if (cnt < MAX_W) begin
            load = 1'b1;
          end else begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end
        end else if (is_eof) begin
          load      = 1'b1;
          ld_eop    = 1'b1;
          ld_err    = (({1'b0, cnt} + 11'd1) < MIN_W);
          state_nxt = IDLE;
        end else if (is_sof) begin
          abort  = 1'b1;
          load   = 1'b1;
          ld_sop = 1'b1;
        end else begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    emit_eop = h_eop | abort;
    emit_err = h_err | abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      h_valid           <= 1'b0;
      h_data            <= '0;
      h_sop             <= 1'b0;
      h_eop             <= 1'b0;
      h_err             <= 1'b0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      frames_ok         <= '0;
      frames_err        <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= emit;
      if (emit) begin
        out_data          <= h_data;
        out_startofpacket <= h_sop;
        out_endofpacket   <= emit_eop;
        out_error         <= emit_err;
        if (emit_eop) begin
          if (emit_err) begin
            if (frames_err != '1) frames_err <= frames_err + 16'd1;
          end else begin
            if (frames_ok != '1) frames_ok <= frames_ok + 16'd1;
          end
        end
      end
      if (load) begin
        h_valid <= 1'b1;
        h_data  <= din;
        h_sop   <= ld_sop;
        h_eop   <= ld_eop;
        h_err   <= ld_err;
        cnt     <= ld_sop ? 10'd1 : cnt + 10'd1;
      end else if (emit) begin
        h_valid <= 1'b0;
      end
    end
  end

  assign in_frame = (state == FRAME);

endmodule

// File: tb/tb_fc_rx_framer.sv
// Directed bench for fc_rx_framer: each step drives one input word and checks the output
// word expected from the word driven one step earlier (two-cycle pipeline).
module tb_fc_rx_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [35:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid, out_startofpacket, out_endofpacket, out_error, in_frame;
  logic [15:0] frames_ok, frames_err;

  int unsigned total  = 0;
  int unsigned passed = 0;

  localparam logic [31:0] IDLE_W = 32'hBC95B5B5;
  localparam logic [31:0] SOFI3  = 32'hBCB55656;
  localparam logic [31:0] SOFN3  = 32'hBCB53636;
  localparam logic [31:0] EOFT   = 32'hBC957575;
  localparam logic [31:0] R_RDY  = 32'hBC954A4A;

  fc_rx_framer #(.MAX_FRAME_WORDS(537), .MIN_FRAME_WORDS(9)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .out_error(out_error), .in_frame(in_frame),
    .frames_ok(frames_ok), .frames_err(frames_err)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] kw(input logic [31:0] d);
    return {4'b1000, d};
  endfunction

  function automatic logic [35:0] dw(input logic [31:0] d);
    return {4'b0000, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step(input logic [35:0] w, input logic v, input logic ev,
                      input logic [31:0] ed, input logic es, input logic ee,
                      input logic er, input string tag);
    in_data  = w;
    in_valid = v;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      chk({tag, ".data"}, out_data, ed);
      chk({tag, ".sop"}, {31'd0, out_startofpacket}, {31'd0, es});
      chk({tag, ".eop"}, {31'd0, out_endofpacket}, {31'd0, ee});
      chk({tag, ".err"}, {31'd0, out_error}, {31'd0, er});
    end
  endtask

  task automatic chk_counts(input string tag, input logic [15:0] ok, input logic [15:0] err);
    chk({tag, ".ok"}, {16'd0, frames_ok}, {16'd0, ok});
    chk({tag, ".errcnt"}, {16'd0, frames_err}, {16'd0, err});
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.data", out_data, 32'd0);
    chk("rst.inframe", {31'd0, in_frame}, 32'd0);
    chk_counts("rst", 16'd0, 16'd0);
    reset_n = 1'b1;

    // Good frame: idles never forwarded, 9 words out, clean eop
    for (int i = 0; i < 4; i++) step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "good.idle");
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "good.sofin");
    chk("good.inframe", {31'd0, in_frame}, 32'd1);
    step(dw(32'd1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "good.sof");
    for (int k = 2; k <= 7; k++)
      step(dw(32'(k)), 1'b1, 1'b1, 32'(k - 1), 1'b0, 1'b0, 1'b0, "good.data");
    step(kw(EOFT), 1'b1, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, "good.d7");
    step(kw(IDLE_W), 1'b1, 1'b1, EOFT, 1'b0, 1'b1, 1'b0, "good.eof");
    chk("good.idle_after", {31'd0, in_frame}, 32'd0);
    step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "good.flushed");
    chk_counts("good", 16'd1, 16'd0);

    // Runt: SOF, 2 DATA, EOF -> error at eop
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "runt.sofin");
    step(dw(32'hA1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "runt.sof");
    step(dw(32'hA2), 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, "runt.d1");
    step(kw(EOFT), 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, "runt.d2");
    step(kw(IDLE_W), 1'b1, 1'b1, EOFT, 1'b0, 1'b1, 1'b1, "runt.eof");
    chk_counts("runt", 16'd1, 16'd1);

    // Abort by primitive: R_RDY mid-frame
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "prim.sofin");
    step(dw(32'hB1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "prim.sof");
    step(dw(32'hB2), 1'b1, 1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, "prim.d1");
    step(dw(32'hB3), 1'b1, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, "prim.d2");
    step(kw(R_RDY), 1'b1, 1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, "prim.d3");
    chk("prim.inframe", {31'd0, in_frame}, 32'd0);
    step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "prim.rrdy");
    chk_counts("prim", 16'd1, 16'd2);

    // Back-to-back SOF: frame A aborted, frame B clean (10 words)
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "b2b.sofa_in");
    step(dw(32'hC1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "b2b.sofa");
    step(dw(32'hC2), 1'b1, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, "b2b.a1");
    step(kw(SOFN3), 1'b1, 1'b1, 32'hC2, 1'b0, 1'b1, 1'b1, "b2b.a2");
    step(dw(32'hD1), 1'b1, 1'b1, SOFN3, 1'b1, 1'b0, 1'b0, "b2b.sofb");
    for (int k = 2; k <= 8; k++)
      step(dw(32'hD0 + 32'(k)), 1'b1, 1'b1, 32'hD0 + 32'(k - 1), 1'b0, 1'b0, 1'b0, "b2b.data");
    step(kw(EOFT), 1'b1, 1'b1, 32'hD8, 1'b0, 1'b0, 1'b0, "b2b.d8");
    step(kw(IDLE_W), 1'b1, 1'b1, EOFT, 1'b0, 1'b1, 1'b0, "b2b.eof");
    chk_counts("b2b", 16'd2, 16'd3);

    // in_valid drop mid-frame
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "drop.sofin");
    step(dw(32'hE1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "drop.sof");
    step(dw(32'hE2), 1'b0, 1'b1, 32'hE1, 1'b0, 1'b1, 1'b1, "drop.d1");
    step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "drop.after");
    chk_counts("drop", 16'd2, 16'd4);

    // SOF immediately followed by a bad K word: single word with sop and eop
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "sopeop.sofin");
    step({4'b0001, 32'h12345678}, 1'b1, 1'b1, SOFI3, 1'b1, 1'b1, 1'b1, "sopeop.sof");
    step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "sopeop.after");
    chk_counts("sopeop", 16'd2, 16'd5);

    // Oversize: the 537th DATA word aborts; trailing words dropped until next SOF
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ovr.sofin");
    step(dw(32'd1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "ovr.sof");
    for (int k = 2; k <= 536; k++)
      step(dw(32'(k)), 1'b1, 1'b1, 32'(k - 1), 1'b0, 1'b0, 1'b0, "ovr.data");
    step(dw(32'd537), 1'b1, 1'b1, 32'd536, 1'b0, 1'b1, 1'b1, "ovr.d536");
    chk("ovr.inframe", {31'd0, in_frame}, 32'd0);
    step(dw(32'd538), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ovr.d537");
    step(dw(32'd539), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ovr.d538");
    step(kw(EOFT), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ovr.d539");
    step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ovr.eof");
    chk_counts("ovr", 16'd2, 16'd6);

    // Asynchronous reset mid-frame: outputs drop at once, no eop afterwards
    step(kw(SOFI3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rstmid.sofin");
    step(dw(32'hF1), 1'b1, 1'b1, SOFI3, 1'b1, 1'b0, 1'b0, "rstmid.sof");
    step(dw(32'hF2), 1'b1, 1'b1, 32'hF1, 1'b0, 1'b0, 1'b0, "rstmid.d1");
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid.valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid.data", out_data, 32'd0);
    chk("rstmid.sop", {31'd0, out_startofpacket}, 32'd0);
    chk("rstmid.inframe", {31'd0, in_frame}, 32'd0);
    chk_counts("rstmid", 16'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step(dw(32'hF3), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rstmid.d3");
    step(kw(IDLE_W), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rstmid.after");
    chk_counts("rstmid_end", 16'd0, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
